// File: rtl/video_mnist_cnn_argmax_if.sv
// Stream bundle for the MNIST argmax stage: vote-vector input stream and
// class/count output stream. The design sits on the slave modport; the
// upstream producer and downstream consumer together form the master side.
interface video_mnist_cnn_argmax_if #(
  parameter int TUSER_WIDTH   = 1,
  parameter int S_TDATA_WIDTH = 70,
  parameter int COUNT_WIDTH   = 3,
  parameter int CLASS_WIDTH   = 4
) ();
  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser;
  logic                     s_axi4s_tlast;
  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata;
  logic                     s_axi4s_tvalid;
  logic                     s_axi4s_tready;

  logic [TUSER_WIDTH-1:0]   m_axi4s_tuser;
  logic                     m_axi4s_tlast;
  logic [CLASS_WIDTH-1:0]   m_axi4s_tclass;
  logic [COUNT_WIDTH-1:0]   m_axi4s_tcount;
  logic                     m_axi4s_tvalid;
  logic                     m_axi4s_tready;

  // Environment side: drives the vote stream and the output ready.
  modport master (
    output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
    input  s_axi4s_tready,
    input  m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tclass, m_axi4s_tcount, m_axi4s_tvalid,
    output m_axi4s_tready
  );

  // Design side.
  modport slave (
    input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
    output s_axi4s_tready,
    output m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tclass, m_axi4s_tcount, m_axi4s_tvalid,
    input  m_axi4s_tready
  );
endinterface

// File: rtl/video_mnist_cnn_argmax.sv
// Per-pixel class decision: popcount each class's binary votes (stage 1),
// then pick the lowest-index class with the highest count and gate it by a
// threshold (stage 2). Both stages share one clock enable so the pipeline
// freezes as a whole under backpressure and bubbles are kept in place.
module video_mnist_cnn_argmax #(
  parameter int TUSER_WIDTH   = 1,
  parameter int NUM_CLASSES   = 10,
  parameter int VOTE_WIDTH    = 7,
  parameter int S_TDATA_WIDTH = NUM_CLASSES * VOTE_WIDTH,
  parameter int COUNT_WIDTH   = 3,
  parameter int CLASS_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] param_threshold,
  video_mnist_cnn_argmax_if.slave axis
);

  logic cke;

  // Per-class popcount of the incoming beat.
  logic [COUNT_WIDTH-1:0] pop_next [NUM_CLASSES];

  // Stage-1 registers.
  logic [COUNT_WIDTH-1:0] s1_count_reg [NUM_CLASSES];
  logic [TUSER_WIDTH-1:0] s1_user_reg;
  logic                   s1_last_reg;
  logic [COUNT_WIDTH-1:0] s1_thresh_reg;
  logic                   s1_valid_reg;

  // Stage-2 (output) registers.
  logic [TUSER_WIDTH-1:0] m_user_reg;
  logic                   m_last_reg;
  logic [CLASS_WIDTH-1:0] m_class_reg;
  logic [COUNT_WIDTH-1:0] m_count_reg;
  logic                   m_valid_reg;

  // Argmax result of stage 1, consumed by stage 2.
  logic [COUNT_WIDTH-1:0] best_count;
  logic [CLASS_WIDTH-1:0] best_class;
  logic [CLASS_WIDTH-1:0] class_next;

  // The pipeline advances whenever the output slot is empty or being taken.
  assign cke = axis.m_axi4s_tready | ~m_valid_reg;
  assign axis.s_axi4s_tready = cke;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_pop
      logic [COUNT_WIDTH-1:0] cnt;
      // Count the set votes of class gi.
      always_comb begin
        cnt = '0;
        for (int j = 0; j < VOTE_WIDTH; j++) begin
          cnt = cnt + COUNT_WIDTH'(axis.s_axi4s_tdata[gi*VOTE_WIDTH + j]);
        end
      end
      assign pop_next[gi] = cnt;
    end
  endgenerate

  // Stage 1: capture counts, sideband, threshold and valid for this beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CLASSES; c++) s1_count_reg[c] <= '0;
      s1_user_reg   <= '0;
      s1_last_reg   <= 1'b0;
      s1_thresh_reg <= '0;
      s1_valid_reg  <= 1'b0;
    end else if (cke) begin
      for (int c = 0; c < NUM_CLASSES; c++) s1_count_reg[c] <= pop_next[c];
      s1_user_reg   <= axis.s_axi4s_tuser;
      s1_last_reg   <= axis.s_axi4s_tlast;
      s1_thresh_reg <= param_threshold;
      s1_valid_reg  <= axis.s_axi4s_tvalid;
    end
  end

  // Argmax with strict-greater replacement so ties resolve to the lowest
  // index; a winner below threshold is reported as the "none" class.
  always_comb begin
    best_count = s1_count_reg[0];
    best_class = '0;
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (s1_count_reg[c] > best_count) begin
        best_count = s1_count_reg[c];
        best_class = CLASS_WIDTH'(c);
      end
    end
    class_next = (best_count < s1_thresh_reg) ? CLASS_WIDTH'(NUM_CLASSES) : best_class;
  end

  // Stage 2: register the decision; these registers drive the output stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_user_reg  <= '0;
      m_last_reg  <= 1'b0;
      m_class_reg <= '0;
      m_count_reg <= '0;
      m_valid_reg <= 1'b0;
    end else if (cke) begin
      m_user_reg  <= s1_user_reg;
      m_last_reg  <= s1_last_reg;
      m_class_reg <= class_next;
      m_count_reg <= best_count;
      m_valid_reg <= s1_valid_reg;
    end
  end

  assign axis.m_axi4s_tuser  = m_user_reg;
  assign axis.m_axi4s_tlast  = m_last_reg;
  assign axis.m_axi4s_tclass = m_class_reg;
  assign axis.m_axi4s_tcount = m_count_reg;
  assign axis.m_axi4s_tvalid = m_valid_reg;

endmodule

// File: tb/tb_video_mnist_cnn_argmax.sv
// Bench for the MNIST argmax stage: directed corner beats, backpressure,
// mid-stream reset and long randomized streams against a reference model.
module tb_video_mnist_cnn_argmax;

  localparam int NC = 10;
  localparam int VW = 7;
  localparam int DW = NC * VW;

  typedef struct packed {
    logic [3:0] cls;
    logic [2:0] cnt;
    logic       user;
    logic       last;
    int         step;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    thr;

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;
  int n_beats = 0;
  int n_pushed = 0;
  bit lat_chk = 1'b0;
  exp_t exp_q[$];

  video_mnist_cnn_argmax_if #(.TUSER_WIDTH(1), .S_TDATA_WIDTH(DW), .COUNT_WIDTH(3), .CLASS_WIDTH(4)) axis ();

  video_mnist_cnn_argmax dut (
    .clk(clk),
    .reset(reset),
    .param_threshold(thr),
    .axis(axis)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: count votes per class, find the maximum, first class holding it.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [2:0] t,
                                 input logic u, input logic l);
    exp_t r;
    int cnt[NC];
    int mx = 0;
    int idx = -1;
    logic [VW-1:0] grp;
    for (int c = 0; c < NC; c++) begin
      grp = d[c*VW +: VW];
      cnt[c] = $countones(grp);
      if (cnt[c] > mx) mx = cnt[c];
    end
    for (int c = NC - 1; c >= 0; c--) if (cnt[c] == mx) idx = c;
    r.cls  = (mx < int'(t)) ? 4'(NC) : 4'(idx);
    r.cnt  = 3'(mx);
    r.user = u;
    r.last = l;
    r.step = 0;
    return r;
  endfunction

  function automatic logic [DW-1:0] grp_vec(input int c, input logic [VW-1:0] v);
    logic [DW-1:0] d = '0;
    d[c*VW +: VW] = v;
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_votes();
    logic [DW-1:0] d = '0;
    logic [VW-1:0] v;
    for (int c = 0; c < NC; c++) begin
      v = VW'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & VW'($urandom);
        1: v = v | VW'($urandom);
        2: v = v & VW'($urandom) & VW'($urandom);
        default: ;
      endcase
      d[c*VW +: VW] = v;
    end
    return d;
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit u, input bit l,
                       input logic [2:0] t, input bit mr);
    axis.s_axi4s_tvalid = v;
    axis.s_axi4s_tdata  = d;
    axis.s_axi4s_tuser  = u;
    axis.s_axi4s_tlast  = l;
    thr                 = t;
    axis.m_axi4s_tready = mr;
  endtask

  // One clock: observe handshakes just before the edge, update the scoreboard.
  task automatic step();
    exp_t e;
    #1;
    check_val("s_tready_rule", axis.s_axi4s_tready,
              !(axis.m_axi4s_tvalid && !axis.m_axi4s_tready));
    if (!reset && axis.m_axi4s_tvalid && axis.m_axi4s_tready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("tclass", axis.m_axi4s_tclass, e.cls);
        check_val("tcount", axis.m_axi4s_tcount, e.cnt);
        check_val("tuser",  axis.m_axi4s_tuser,  e.user);
        check_val("tlast",  axis.m_axi4s_tlast,  e.last);
        if (lat_chk) check_val("latency", step_no - e.step, 2);
        n_beats++;
        $display("[TB] beat %0d class %0d count %0d user %0d last %0d",
                 n_beats, axis.m_axi4s_tclass, axis.m_axi4s_tcount,
                 axis.m_axi4s_tuser, axis.m_axi4s_tlast);
      end
    end
    if (!reset && axis.s_axi4s_tvalid && axis.s_axi4s_tready) begin
      e = model(axis.s_axi4s_tdata, thr, axis.s_axi4s_tuser[0], axis.s_axi4s_tlast);
      e.step = step_no;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    if (reset) exp_q.delete();
    step_no++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit mr);
    drive(1'b0, '0, 1'b0, 1'b0, 3'd0, mr);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic stream(input int beats, input bit rand_thr);
    int start = n_pushed;
    int guard = 0;
    while ((n_pushed - start) < beats && guard < 20000) begin
      drive(1'($urandom), rand_votes(), 1'($urandom), 1'($urandom),
            rand_thr ? 3'($urandom) : 3'd0, 1'($urandom));
      step();
      guard++;
    end
    check_val("stream_accepted", n_pushed - start, beats);
    idle(6, 1'b1);
    check_val("stream_drained", exp_q.size(), 0);
  endtask

  initial begin
    exp_t ea;
    int b0;
    logic [DW-1:0] da, db;

    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    step();
    step();
    check_val("rst_tvalid", axis.m_axi4s_tvalid, 0);
    check_val("rst_tuser",  axis.m_axi4s_tuser,  0);
    check_val("rst_tlast",  axis.m_axi4s_tlast,  0);
    check_val("rst_tclass", axis.m_axi4s_tclass, 0);
    check_val("rst_tcount", axis.m_axi4s_tcount, 0);
    check_val("rst_tready", axis.s_axi4s_tready, 1);
    reset = 1'b0;
    step();
    check_val("post_rst_tready", axis.s_axi4s_tready, 1);

    // Directed beats, uninterrupted output, latency checked.
    lat_chk = 1'b1;
    drive(1'b1, grp_vec(3, 7'h7F), 1'b1, 1'b1, 3'd4, 1'b1); step();
    idle(3, 1'b1);
    drive(1'b1, grp_vec(2, 7'h0F) | grp_vec(7, 7'h0F), 1'b0, 1'b1, 3'd1, 1'b1); step();
    drive(1'b1, grp_vec(5, 7'h07), 1'b1, 1'b0, 3'd4, 1'b1); step();
    drive(1'b1, '0, 1'b0, 1'b0, 3'd0, 1'b1); step();
    drive(1'b1, '1, 1'b1, 1'b1, 3'd7, 1'b1); step();
    drive(1'b1, grp_vec(9, 7'h3F) | grp_vec(0, 7'h1F), 1'b0, 1'b0, 3'd7, 1'b1); step();
    idle(3, 1'b1);
    check_val("directed_beats", n_beats, 6);
    check_val("directed_drain", exp_q.size(), 0);

    // Backpressure hold: fill both stages then stall 20 cycles.
    lat_chk = 1'b0;
    da = grp_vec(6, 7'h3E) | grp_vec(1, 7'h03);
    db = grp_vec(8, 7'h7F);
    ea = model(da, 3'd2, 1'b1, 1'b0);
    drive(1'b1, da, 1'b1, 1'b0, 3'd2, 1'b0); step();
    drive(1'b1, db, 1'b0, 1'b1, 3'd2, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("hold_tvalid", axis.m_axi4s_tvalid, 1);
      check_val("hold_tclass", axis.m_axi4s_tclass, ea.cls);
      check_val("hold_tcount", axis.m_axi4s_tcount, ea.cnt);
      check_val("hold_tuser",  axis.m_axi4s_tuser,  ea.user);
      check_val("hold_tready", axis.s_axi4s_tready, 0);
    end
    b0 = n_beats;
    axis.m_axi4s_tready = 1'b1;
    step();
    check_val("release_first", n_beats - b0, 1);
    step();
    check_val("release_second", n_beats - b0, 2);
    idle(2, 1'b1);
    check_val("release_drain", exp_q.size(), 0);

    // Reset with two beats in flight.
    drive(1'b1, grp_vec(4, 7'h55), 1'b1, 1'b0, 3'd0, 1'b1); step();
    drive(1'b1, grp_vec(2, 7'h7F), 1'b0, 1'b1, 3'd0, 1'b1); step();
    drive(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    b0 = n_beats;
    for (int i = 0; i < 3; i++) begin
      axis.m_axi4s_tready = 1'($urandom);
      step();
      check_val("rst_flush_tvalid", axis.m_axi4s_tvalid, 0);
    end
    lat_chk = 1'b1;
    drive(1'b1, grp_vec(1, 7'h33), 1'b1, 1'b1, 3'd3, 1'b1); step();
    idle(3, 1'b1);
    check_val("rst_restart_beats", n_beats - b0, 1);
    check_val("rst_restart_drain", exp_q.size(), 0);
    lat_chk = 1'b0;

    // Randomized streaming with random valid and ready.
    stream(1000, 1'b0);
    stream(300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
